// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_defines (package)
//  Purpose  : Shared definitions for the hardware-loop register file.
//             Write-enable bit positions of hwlp_we_i and the per-loop
//             decrement-tracking state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_defines;

  // Bit positions inside hwlp_we_i
  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

  // Per-loop decrement tracking: IDLE = nothing in flight,
  // PENDING = a decrement is waiting for the loop-end instruction to leave ID.
  typedef enum logic [0:0] {
    HWLP_IDLE    = 1'b0,
    HWLP_PENDING = 1'b1
  } hwlp_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_hwloop_regfile_if.sv
`default_nettype none
// ============================================================================
//  Interface : riscv_hwloop_regfile_if
//  Purpose   : Bundles the ID-stage write port, the controller decrement
//              request and the loop register read-back of the hardware-loop
//              register file.
//  Ports     : master = ID stage / loop controller side
//              slave  = riscv_hwloop_regfile
//  Revision  : 1.0  initial release
// ============================================================================
interface riscv_hwloop_regfile_if #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
);

  logic [31:0]               hwlp_start_data_i;
  logic [31:0]               hwlp_end_data_i;
  logic [31:0]               hwlp_cnt_data_i;
  logic [2:0]                hwlp_we_i;
  logic [N_REG_BITS-1:0]     hwlp_regid_i;
  logic [N_REGS-1:0]         hwlp_dec_cnt_i;
  logic                      id_valid_i;
  logic                      id_flush_i;

  logic [N_REGS-1:0][31:0]   hwlp_start_addr_o;
  logic [N_REGS-1:0][31:0]   hwlp_end_addr_o;
  logic [N_REGS-1:0][31:0]   hwlp_counter_o;
  logic [N_REGS-1:0]         hwlp_dec_cnt_id_o;

  modport master (
    output hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i,
    output hwlp_we_i, hwlp_regid_i, hwlp_dec_cnt_i, id_valid_i, id_flush_i,
    input  hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_dec_cnt_id_o
  );

  modport slave (
    input  hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i,
    input  hwlp_we_i, hwlp_regid_i, hwlp_dec_cnt_i, id_valid_i, id_flush_i,
    output hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_dec_cnt_id_o
  );

endinterface
`default_nettype wire

// File: rtl/riscv_hwloop_reg_entry.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_hwloop_reg_entry
//  Purpose  : One hardware loop: start/end/counter registers, the in-flight
//             decrement flag and the saturating decrementer.
//  Ports    : clk, rst_n (sync, active-low)
//             we_*_i / *_data_i : already-decoded writes for this loop
//             dec_req_i         : controller decrement request for this loop
//             id_valid_i        : loop-end instruction leaves ID
//             id_flush_i        : squash the in-flight decrement
//             start_addr_o, end_addr_o, counter_o, dec_pending_o : registered
//  Revision : 1.0  initial release
// ============================================================================
module riscv_hwloop_reg_entry
  import riscv_defines::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_start_i,
  input  logic        we_end_i,
  input  logic        we_cnt_i,
  input  logic [31:0] start_data_i,
  input  logic [31:0] end_data_i,
  input  logic [31:0] cnt_data_i,
  input  logic        dec_req_i,
  input  logic        id_valid_i,
  input  logic        id_flush_i,
  output logic [31:0] start_addr_o,
  output logic [31:0] end_addr_o,
  output logic [31:0] counter_o,
  output logic        dec_pending_o
);

  hwlp_state_e state_q, state_d;
  logic [31:0] start_q, start_d;
  logic [31:0] end_q, end_d;
  logic [31:0] cnt_q, cnt_d;
  logic        dec_apply;

  // Next-state / decrement-apply logic
  always_comb begin
    state_d   = state_q;
    dec_apply = 1'b0;
    case (state_q)
      HWLP_IDLE: begin
        // A request arriving during a flush is dropped
        if (dec_req_i && !id_flush_i) state_d = HWLP_PENDING;
      end
      HWLP_PENDING: begin
        // Flush beats id_valid: the squashed loop-end must not count
        if (id_flush_i) begin
          state_d = HWLP_IDLE;
        end else if (id_valid_i) begin
          dec_apply = 1'b1;
          state_d   = dec_req_i ? HWLP_PENDING : HWLP_IDLE;
        end
      end
      default: state_d = HWLP_IDLE;
    endcase
    // A counter write discards any in-flight decrement of this loop
    if (we_cnt_i) state_d = HWLP_IDLE;
  end

  // Register write / decrement datapath
  always_comb begin
    start_d = we_start_i ? start_data_i : start_q;
    end_d   = we_end_i   ? end_data_i   : end_q;
    cnt_d   = cnt_q;
    if (we_cnt_i) begin
      cnt_d = cnt_data_i;
    end else if (dec_apply && (cnt_q != 32'd0)) begin
      cnt_d = cnt_q - 32'd1;  // saturate at zero, never wrap
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HWLP_IDLE;
      start_q <= 32'd0;
      end_q   <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_addr_o  = start_q;
  assign end_addr_o    = end_q;
  assign counter_o     = cnt_q;
  assign dec_pending_o = (state_q == HWLP_PENDING);

endmodule
`default_nettype wire

// File: rtl/riscv_hwloop_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_hwloop_regfile
//  Purpose  : Hardware-loop register file for the RI5CY core. Decodes the
//             loop index of ID-stage writes and packs the per-loop entries
//             onto the read-back bus.
//  Ports    : clk, rst_n (sync, active-low)
//             bus : riscv_hwloop_regfile_if.slave (write port, decrement
//                   request, registered loop registers and pending flags)
//  Revision : 1.0  initial release
// ============================================================================
module riscv_hwloop_regfile
  import riscv_defines::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_hwloop_regfile_if.slave bus
);

  logic [N_REGS-1:0]       sel;
  logic [N_REGS-1:0][31:0] start_addr;
  logic [N_REGS-1:0][31:0] end_addr;
  logic [N_REGS-1:0][31:0] counter;
  logic [N_REGS-1:0]       dec_pending;

  // An index >= N_REGS selects nothing, so such writes are ignored
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REGS; i++) begin
      sel[i] = (int'(bus.hwlp_regid_i) == i);
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_loop
    riscv_hwloop_reg_entry u_entry (
      .clk           (clk),
      .rst_n         (rst_n),
      .we_start_i    (bus.hwlp_we_i[HWLP_WE_START] & sel[g]),
      .we_end_i      (bus.hwlp_we_i[HWLP_WE_END]   & sel[g]),
      .we_cnt_i      (bus.hwlp_we_i[HWLP_WE_CNT]   & sel[g]),
      .start_data_i  (bus.hwlp_start_data_i),
      .end_data_i    (bus.hwlp_end_data_i),
      .cnt_data_i    (bus.hwlp_cnt_data_i),
      .dec_req_i     (bus.hwlp_dec_cnt_i[g]),
      .id_valid_i    (bus.id_valid_i),
      .id_flush_i    (bus.id_flush_i),
      .start_addr_o  (start_addr[g]),
      .end_addr_o    (end_addr[g]),
      .counter_o     (counter[g]),
      .dec_pending_o (dec_pending[g])
    );
  end

  assign bus.hwlp_start_addr_o = start_addr;
  assign bus.hwlp_end_addr_o   = end_addr;
  assign bus.hwlp_counter_o    = counter;
  assign bus.hwlp_dec_cnt_id_o = dec_pending;

endmodule
`default_nettype wire

// File: tb/tb_riscv_hwloop_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_hwloop_regfile
//  Purpose  : Self-checking bench for riscv_hwloop_regfile (N_REGS=3).
//             Driver applies inputs on the falling edge and queues the
//             reference model's expected post-edge outputs; a monitor pops
//             and compares one entry after every rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_hwloop_regfile;

  localparam int N  = 3;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_hwloop_regfile_if #(.N_REGS(N), .N_REG_BITS(NB)) bus ();

  riscv_hwloop_regfile #(.N_REGS(N), .N_REG_BITS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0][31:0] s;
    logic [N-1:0][31:0] e;
    logic [N-1:0][31:0] c;
    logic [N-1:0]       p;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain per-loop variables
  int unsigned m_start [N];
  int unsigned m_end   [N];
  int unsigned m_cnt   [N];
  bit          m_pend  [N];

  int vectors     = 0;
  int miscompares = 0;

  // Apply the rules for one clock edge to the model and queue the result.
  task automatic step();
    exp_t x;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_start[i] = 0; m_end[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
      end else begin
        bit hit;
        hit = (int'(bus.hwlp_regid_i) == i);
        if (hit && bus.hwlp_we_i[0]) m_start[i] = bus.hwlp_start_data_i;
        if (hit && bus.hwlp_we_i[1]) m_end[i]   = bus.hwlp_end_data_i;
        if (hit && bus.hwlp_we_i[2]) begin
          m_cnt[i]  = bus.hwlp_cnt_data_i;
          m_pend[i] = 0;
        end else if (m_pend[i]) begin
          if (bus.id_flush_i) m_pend[i] = 0;
          else if (bus.id_valid_i) begin
            if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            m_pend[i] = bus.hwlp_dec_cnt_i[i];
          end
        end else begin
          m_pend[i] = bus.hwlp_dec_cnt_i[i] && !bus.id_flush_i;
        end
      end
      x.s[i] = m_start[i];
      x.e[i] = m_end[i];
      x.c[i] = m_cnt[i];
      x.p[i] = m_pend[i];
    end
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] we, input int rid, input int unsigned s,
                       input int unsigned e, input int unsigned c,
                       input logic [N-1:0] dec, input bit v, input bit f);
    bus.hwlp_we_i         = we;
    bus.hwlp_regid_i      = NB'(rid);
    bus.hwlp_start_data_i = s;
    bus.hwlp_end_data_i   = e;
    bus.hwlp_cnt_data_i   = c;
    bus.hwlp_dec_cnt_i    = dec;
    bus.id_valid_i        = v;
    bus.id_flush_i        = f;
    step();
  endtask

  task automatic idle();
    drive(3'b000, 0, 0, 0, 0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: compare once after every rising edge
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      vectors++;
      if (bus.hwlp_start_addr_o !== x.s) begin
        miscompares++;
        $display("FAIL start_addr t=%0t got %h exp %h", $time, bus.hwlp_start_addr_o, x.s);
      end
      vectors++;
      if (bus.hwlp_end_addr_o !== x.e) begin
        miscompares++;
        $display("FAIL end_addr t=%0t got %h exp %h", $time, bus.hwlp_end_addr_o, x.e);
      end
      vectors++;
      if (bus.hwlp_counter_o !== x.c) begin
        miscompares++;
        $display("FAIL counter t=%0t got %h exp %h", $time, bus.hwlp_counter_o, x.c);
      end
      vectors++;
      if (bus.hwlp_dec_cnt_id_o !== x.p) begin
        miscompares++;
        $display("FAIL dec_pending t=%0t got %b exp %b", $time, bus.hwlp_dec_cnt_id_o, x.p);
      end
    end
  end

  // Controller contract: at most one decrement request per cycle
  always @(posedge clk) begin
    assert ($countones(bus.hwlp_dec_cnt_i) <= 1)
      else $error("illegal multi-bit hwlp_dec_cnt_i %b", bus.hwlp_dec_cnt_i);
  end

  initial begin
    rst_n = 1'b0;
    bus.hwlp_we_i = '0; bus.hwlp_regid_i = '0;
    bus.hwlp_start_data_i = '0; bus.hwlp_end_data_i = '0; bus.hwlp_cnt_data_i = '0;
    bus.hwlp_dec_cnt_i = '0; bus.id_valid_i = 1'b0; bus.id_flush_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_start[i] = 0; m_end[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
    end
    @(negedge clk);

    // Reset state
    idle(); idle();
    rst_n = 1'b1;
    idle();

    // Loop 1 full write in one cycle
    drive(3'b111, 1, 32'h100, 32'h140, 5, '0, 1'b0, 1'b0);
    idle();

    // Basic decrement: request, wait, id_valid
    drive(3'b100, 0, 0, 0, 3, '0, 1'b0, 1'b0);
    drive(3'b000, 0, 0, 0, 0, 3'b001, 1'b0, 1'b0);
    idle();
    drive(3'b000, 0, 0, 0, 0, '0, 1'b1, 1'b0);
    idle();

    // Request together with id_valid while pending: one decrement, flag held
    drive(3'b100, 0, 0, 0, 2, '0, 1'b0, 1'b0);
    drive(3'b000, 0, 0, 0, 0, 3'b001, 1'b0, 1'b0);
    drive(3'b000, 0, 0, 0, 0, 3'b001, 1'b1, 1'b0);
    idle();
    drive(3'b000, 0, 0, 0, 0, '0, 1'b1, 1'b0);
    idle();

    // Flush and id_valid together while pending: flag cleared, no decrement
    drive(3'b100, 0, 0, 0, 7, '0, 1'b0, 1'b0);
    drive(3'b000, 0, 0, 0, 0, 3'b001, 1'b0, 1'b0);
    drive(3'b000, 0, 0, 0, 0, '0, 1'b1, 1'b1);
    // Request dropped in a flush cycle
    drive(3'b000, 0, 0, 0, 0, 3'b001, 1'b0, 1'b1);
    idle();

    // Counter write races an applied decrement on loop 0; loop 1 proceeds
    drive(3'b000, 0, 0, 0, 0, 3'b001, 1'b0, 1'b0);
    drive(3'b000, 0, 0, 0, 0, 3'b010, 1'b0, 1'b0);
    drive(3'b100, 0, 0, 0, 10, '0, 1'b1, 1'b0);
    idle();

    // Saturation at zero on loop 2
    drive(3'b000, 0, 0, 0, 0, 3'b100, 1'b0, 1'b0);
    drive(3'b000, 0, 0, 0, 0, '0, 1'b1, 1'b0);
    idle();

    // Out-of-range index: ignored
    drive(3'b111, 3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234, '0, 1'b0, 1'b0);
    idle();

    // Reset mid-operation drops in-flight decrement
    drive(3'b000, 0, 0, 0, 0, 3'b010, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(3'b000, 0, 0, 0, 0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    idle();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [2:0]   we;
      logic [N-1:0] dec;
      int unsigned  r, c;
      rst_n = ($urandom_range(0, 99) != 0);
      we    = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(0, 7)) : 3'b000;
      c     = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom;
      r     = $urandom_range(0, 5);
      dec   = (r < N) ? N'(1 << r) : '0;
      drive(we, int'($urandom_range(0, 3)), $urandom, $urandom, c, dec,
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end
    rst_n = 1'b1;
    idle();

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d queued exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
